icache: RTL and testbench

//  Direct-mapped, read-only instruction cache. It answers the fetch stage's per-cycle address with a

---
 rtl/icache.sv | 164 ++++++++++++++++
 tb/tb_icache.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with same-cycle hit and
// whole-line refill from the instruction memory bus.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   icache_adr_i, icache_req_i   fetch byte address and request
//   icache_instr_o, icache_hit_o instruction (0 unless hit) and hit flag
//   icache_inval_i               invalidate all lines (fence.i)
//   mem_req_o, mem_adr_o         refill request and line base address
//   mem_gnt_i                    memory accepted the refill request
//   mem_rvalid_i, mem_rdata_i    refill beats, ascending from line base
module icache #(
  parameter int XLEN       = 32,
  parameter int NB_LINES   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] icache_adr_i,
  input  logic            icache_req_i,
  output logic [31:0]     icache_instr_o,
  output logic            icache_hit_o,
  input  logic            icache_inval_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [31:0]     mem_rdata_i
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(NB_LINES);
  localparam int TAG = XLEN - OFF - IDX;

  localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } state_t;

  state_t state_q, state_d;

  logic [NB_LINES-1:0] valid_q;
  logic [TAG-1:0]      tag_q  [NB_LINES];
  logic [31:0]         data_q [NB_LINES][LINE_WORDS];

  logic [XLEN-1:0] miss_adr_q, miss_adr_d;
  logic [WB-1:0]   cnt_q, cnt_d;
  logic            drop_q, drop_d;

  logic            fill_we;
  logic            fill_last;
  logic            hit;

  logic [TAG-1:0]  adr_tag;
  logic [IDX-1:0]  adr_idx;
  logic [WB-1:0]   adr_word;
  logic [TAG-1:0]  miss_tag;
  logic [IDX-1:0]  miss_idx;

  logic            unused_bits;

  assign adr_tag  = icache_adr_i[XLEN-1 -: TAG];
  assign adr_idx  = icache_adr_i[OFF +: IDX];
  assign adr_word = icache_adr_i[2 +: WB];
  assign miss_tag = miss_adr_q[XLEN-1 -: TAG];
  assign miss_idx = miss_adr_q[OFF +: IDX];

  // byte offset never selects anything
  assign unused_bits = ^{icache_adr_i[1:0],
                         miss_adr_q[OFF-1:0]};

  // No hit-under-miss: lookups only answer in IDLE.
  assign hit = icache_req_i
             && (state_q == IDLE)
             && valid_q[adr_idx]
             && (tag_q[adr_idx] == adr_tag);

  assign icache_hit_o   = hit;
  assign icache_instr_o = hit
                        ? data_q[adr_idx][adr_word]
                        : 32'h0;

  always_comb begin
    state_d    = state_q;
    miss_adr_d = miss_adr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    mem_req_o  = 1'b0;
    mem_adr_o  = '0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (icache_req_i && !hit) begin
          miss_adr_d = {icache_adr_i[XLEN-1:OFF],
                        {OFF{1'b0}}};
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        mem_adr_o = miss_adr_q;
        if (icache_inval_i) drop_d = 1'b1;
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (icache_inval_i) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + WB'(1);
          if (cnt_q == LAST) begin
            fill_last = 1'b1;
            // line is done; next miss starts clean
            drop_d    = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      miss_adr_q <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_adr_q <= miss_adr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

  // Invalidate beats a completing fill, even on the final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (icache_inval_i) begin
      valid_q <= '0;
    end else if (fill_last && !drop_q) begin
      valid_q[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[miss_idx][cnt_q] <= mem_rdata_i;
    end
    if (fill_last) begin
      tag_q[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: fetch driver, memory responder
// and hit monitor against a line-residency reference model.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] icache_adr_i = '0;
  logic        icache_req_i = 1'b0;
  logic [31:0] icache_instr_o;
  logic        icache_hit_o;
  logic        icache_inval_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_adr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  icache dut (
    .clk           (clk),
    .reset         (reset),
    .icache_adr_i  (icache_adr_i),
    .icache_req_i  (icache_req_i),
    .icache_instr_o(icache_instr_o),
    .icache_hit_o  (icache_hit_o),
    .icache_inval_i(icache_inval_i),
    .mem_req_o     (mem_req_o),
    .mem_adr_o     (mem_adr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        first;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] miss_q [$];
  logic [31:0] mem [logic [31:0]];

  bit          ref_valid [16];
  logic [31:0] ref_base  [16];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int inval_beat = -1;
  int reset_beat = -1;
  bit slow_gnt = 0;
  bit gap_mode = 0;
  bit rst_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Monitor: each hit retires the oldest outstanding fetch.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && icache_hit_o) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_hit");
      end else begin
        e = exp_q.pop_front();
        check("instr", icache_instr_o, e.data);
        check("hit_cycle", 32'(cyc == issue_cyc),
              32'(e.first));
      end
    end
  end

  // Memory responder: owns reset, gnt, rvalid and inval.
  task automatic serve();
    logic [31:0] base;
    int gw, ib, rb, beat, gi;
    bit v, aborted;
    int gp [7] = '{1, 0, 0, 1, 1, 0, 1};
    base = mem_adr_o;
    ib = inval_beat;
    rb = reset_beat;
    inval_beat = -1;
    reset_beat = -1;
    if (miss_q.size() == 0) fail("unexpected_miss");
    else check("miss_adr", base, miss_q.pop_front());
    gw = slow_gnt ? 5 : $urandom_range(0, 2);
    for (int i = 0; i <= gw; i++) begin
      check("req_hold", {mem_req_o, mem_adr_o[30:0]},
            {1'b1, base[30:0]});
      check("req_adr", mem_adr_o, base);
      mem_gnt_i = (i == gw);
      @(posedge clk); #1;
    end
    mem_gnt_i = 1'b0;
    check("req_drop", mem_req_o, 0);
    beat = 0;
    gi = 0;
    aborted = 0;
    while (beat < 4) begin
      if (!aborted) check("refill_no_hit", icache_hit_o, 0);
      if (!aborted && beat == rb) begin
        reset = 1'b1;
        #1;
        check("rst_req", mem_req_o, 0);
        check("rst_adr", mem_adr_o, 0);
        check("rst_hit", icache_hit_o, 0);
        check("rst_instr", icache_instr_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        aborted = 1;
      end else begin
        if (gap_mode) v = (gi < 7) ? gp[gi][0] : 1'b1;
        else v = ($urandom_range(0, 3) != 0);
        gi++;
        mem_rvalid_i = v;
        mem_rdata_i = aborted ? $urandom
                              : mem_word(base + 4 * beat);
        icache_inval_i = v && !aborted && (beat == ib);
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        icache_inval_i = 1'b0;
        if (v) beat++;
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    check("reset_hit", icache_hit_o, 0);
    check("reset_instr", icache_instr_o, 0);
    check("reset_req", mem_req_o, 0);
    check("reset_adr", mem_adr_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rst_done = 1;
    forever begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      icache_inval_i = 1'b0;
      if (mem_req_o) begin
        serve();
      end else begin
        // stray gnt/rvalid while idle must be ignored
        mem_gnt_i = ($urandom_range(0, 3) == 0);
        mem_rvalid_i = ($urandom_range(0, 3) == 0);
        mem_rdata_i = $urandom;
        @(posedge clk); #1;
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input int ib, input int rb);
    logic [31:0] base;
    int idx;
    bit h, done;
    exp_t e;
    base = a & 32'hFFFF_FFF0;
    idx = int'((a >> 4) % 16);
    h = ref_valid[idx] && (ref_base[idx] == base);
    e.data = mem_word(a & 32'hFFFF_FFFC);
    e.first = h;
    exp_q.push_back(e);
    if (!h) begin
      miss_q.push_back(base);
      if (ib >= 0 || rb >= 0) begin
        // first fill is lost; the held fetch misses again
        miss_q.push_back(base);
        for (int i = 0; i < 16; i++) ref_valid[i] = 0;
        inval_beat = ib;
        reset_beat = rb;
      end
      ref_valid[idx] = 1;
      ref_base[idx] = base;
    end
    @(posedge clk); #1;
    icache_adr_i = a;
    icache_req_i = 1'b1;
    issue_cyc = cyc;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = icache_hit_o;
    end
    if (!done) fail("fetch_timeout");
  endtask

  task automatic idle(input logic [31:0] a);
    @(posedge clk); #1;
    icache_req_i = 1'b0;
    icache_adr_i = a;
    @(negedge clk);
    check("idle_hit", icache_hit_o, 0);
    check("idle_instr", icache_instr_o, 0);
  endtask

  initial begin
    int ib;
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 0;
      ref_base[i] = '0;
    end
    mem[32'h0] = 32'h11;
    mem[32'h4] = 32'h22;
    mem[32'h8] = 32'h33;
    mem[32'hC] = 32'h44;
    mem[32'h100] = 32'hA0;
    mem[32'h104] = 32'hA1;
    mem[32'h108] = 32'hA2;
    mem[32'h10C] = 32'hA3;
    wait (rst_done);

    fetch(32'h0, -1, -1);
    fetch(32'h8, -1, -1);
    fetch(32'h100, -1, -1);
    fetch(32'h100, -1, -1);
    fetch(32'h10E, -1, -1);
    fetch(32'h0, -1, -1);

    slow_gnt = 1;
    fetch(32'h40, -1, -1);
    slow_gnt = 0;
    fetch(32'h44, -1, -1);

    gap_mode = 1;
    fetch(32'h8C, -1, -1);
    gap_mode = 0;
    fetch(32'h80, -1, -1);
    fetch(32'h84, -1, -1);
    fetch(32'h88, -1, -1);

    fetch(32'h0, -1, -1);
    fetch(32'h20, 2, -1);
    fetch(32'h0, -1, -1);
    fetch(32'h34, 3, -1);
    fetch(32'h34, -1, -1);

    for (int i = 0; i < 3; i++) idle(32'h0);

    fetch(32'h50, -1, 1);
    fetch(32'h0, -1, -1);
    fetch(32'h4, -1, -1);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0)
        idle(32'($urandom_range(0, 1023)));
      ib = ($urandom_range(0, 9) == 0)
         ? int'($urandom_range(0, 3)) : -1;
      fetch(32'($urandom_range(0, 1023)), ib, -1);
    end

    for (int i = 0; i < 4; i++) idle(32'h0);
    check("exp_q_empty", exp_q.size(), 0);
    check("miss_q_empty", miss_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    wait (cyc > 60000);
    $display("FAIL watchdog: got %0d cycles expected < 60000",
             cyc);
    $fatal(1, "watchdog");
  end

endmodule
